// File: rtl/vreg_wb_scoreboard.sv
// Purpose: round-robin writeback arbiter for the vector regfile write port, plus a per-register busy scoreboard.
// Latency: a handshake in cycle N appears on vregw_en_o/vrd_addr_o/vrd_data_o in N+1; busy clears at the end of N+1.
// Backpressure: none on writeback; one grant every cycle any wb_valid_i is set. A reservation of a busy register is refused.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   rsv_valid_i/rsv_vd_i         reserve a destination; rsv_ready_o accepts it
//   chk_vs1_i/chk_vs2_i          sources to hazard-check; chk_hazard_o (combinational)
//   wb_valid_i/wb_vd_i/wb_data_i per-requester writeback; requester k at [5k+:5] / [VLEN*k+:VLEN]
//   wb_ready_o                   one-hot grant
//   vregw_en_o/vrd_addr_o/vrd_data_o  registered regfile write port
//   busy_o                       scoreboard busy bits
//   err_o                        sticky error: write to a register that was not reserved
// Optional feature: define VREG_WB_SB_CHECK_EN to build the err_o check; otherwise err_o is tied 0.

module vreg_wb_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 8,
  parameter int VLEN       = DATA_WIDTH * ELEMENTS,
  parameter int VREGS      = 32,
  parameter int NREQ       = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rsv_valid_i,
  input  logic [4:0]           rsv_vd_i,
  output logic                 rsv_ready_o,
  input  logic [4:0]           chk_vs1_i,
  input  logic [4:0]           chk_vs2_i,
  output logic                 chk_hazard_o,
  input  logic [NREQ-1:0]      wb_valid_i,
  input  logic [NREQ*5-1:0]    wb_vd_i,
  input  logic [NREQ*VLEN-1:0] wb_data_i,
  output logic [NREQ-1:0]      wb_ready_o,
  output logic                 vregw_en_o,
  output logic [4:0]           vrd_addr_o,
  output logic [VLEN-1:0]      vrd_data_o,
  output logic [VREGS-1:0]     busy_o,
  output logic                 err_o
);

  localparam int AW = 5;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [VREGS-1:0] busy;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant_idx;
  logic             grant_vld;
  logic [NREQ-1:0]  grant_oh;
  logic [AW-1:0]    g_vd;
  logic [VLEN-1:0]  g_data;
  logic             g_write;

  // Scan requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_vld && wb_valid_i[(int'(rr_ptr) + i) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
    grant_oh[grant_idx] = grant_vld;
  end

  assign wb_ready_o = grant_oh;
  assign g_vd       = wb_vd_i[AW*grant_idx +: AW];
  assign g_data     = wb_data_i[VLEN*grant_idx +: VLEN];
  // v0 is hardwired zero: its writebacks are accepted and dropped.
  assign g_write    = grant_vld && (g_vd != '0);

  // A register is still busy while its write sits on the port, so a
  // same-cycle re-reservation is naturally refused here.
  assign rsv_ready_o  = (rsv_vd_i == '0) || !busy[rsv_vd_i];
  assign chk_hazard_o = (busy[chk_vs1_i] && (chk_vs1_i != '0)) ||
                        (busy[chk_vs2_i] && (chk_vs2_i != '0));
  assign busy_o       = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      // Clear for the write on the port retires at the edge the regfile captures it.
      if (vregw_en_o) begin
        busy[vrd_addr_o] <= 1'b0;
      end
      // Set comes last: if an unreserved register is written and reserved in
      // the same cycle, the newer reservation must survive.
      if (rsv_valid_i && rsv_ready_o && (rsv_vd_i != '0)) begin
        busy[rsv_vd_i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vregw_en_o <= 1'b0;
      vrd_addr_o <= '0;
      vrd_data_o <= '0;
    end else begin
      vregw_en_o <= g_write;
      if (g_write) begin
        vrd_addr_o <= g_vd;
        vrd_data_o <= g_data;
      end
    end
  end

`ifdef VREG_WB_SB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (g_write && !busy[g_vd]) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vreg_wb_scoreboard.sv
module tb_vreg_wb_scoreboard;

  localparam int VLEN  = 256;
  localparam int VREGS = 32;
  localparam int NREQ  = 2;

`ifdef VREG_WB_SB_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 rsv_valid_i;
  logic [4:0]           rsv_vd_i;
  logic                 rsv_ready_o;
  logic [4:0]           chk_vs1_i;
  logic [4:0]           chk_vs2_i;
  logic                 chk_hazard_o;
  logic [NREQ-1:0]      wb_valid_i;
  logic [NREQ*5-1:0]    wb_vd_i;
  logic [NREQ*VLEN-1:0] wb_data_i;
  logic [NREQ-1:0]      wb_ready_o;
  logic                 vregw_en_o;
  logic [4:0]           vrd_addr_o;
  logic [VLEN-1:0]      vrd_data_o;
  logic [VREGS-1:0]     busy_o;
  logic                 err_o;

  vreg_wb_scoreboard #(
    .DATA_WIDTH(32), .ELEMENTS(8), .VLEN(VLEN), .VREGS(VREGS), .NREQ(NREQ)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rsv_valid_i(rsv_valid_i), .rsv_vd_i(rsv_vd_i), .rsv_ready_o(rsv_ready_o),
    .chk_vs1_i(chk_vs1_i), .chk_vs2_i(chk_vs2_i), .chk_hazard_o(chk_hazard_o),
    .wb_valid_i(wb_valid_i), .wb_vd_i(wb_vd_i), .wb_data_i(wb_data_i), .wb_ready_o(wb_ready_o),
    .vregw_en_o(vregw_en_o), .vrd_addr_o(vrd_addr_o), .vrd_data_o(vrd_data_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      addr;
    logic [VLEN-1:0] data;
    int              cyc;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  logic [31:0] w0, w1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Writes are compared against the queue in order and must land in the cycle promised.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_write: addr %0d due in cycle %0d, not seen by cycle %0d",
                 exp_q[0].addr, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (vregw_en_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr %0d in cycle %0d", vrd_addr_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (vrd_addr_o !== e.addr || vrd_data_o !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL write: got addr %0d data %h cyc %0d, expected addr %0d data %h cyc %0d",
                     vrd_addr_o, vrd_data_o, cyc, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive writeback requests, check the grant at mid-cycle, queue the write the grant implies.
  task automatic wb_issue(input logic [NREQ-1:0] vld, input logic [4:0] vd0, input logic [4:0] vd1,
                          input logic [VLEN-1:0] d0, input logic [VLEN-1:0] d1,
                          input logic [NREQ-1:0] gnt, input string nm);
    wr_t e;
    wb_valid_i = vld;
    wb_vd_i    = {vd1, vd0};
    wb_data_i  = {d1, d0};
    @(negedge clk);
    check(nm, 64'(wb_ready_o), 64'(gnt));
    if (gnt == 2'b01 && vd0 != 5'd0) begin
      e.addr = vd0; e.data = d0; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end else if (gnt == 2'b10 && vd1 != 5'd0) begin
      e.addr = vd1; e.data = d1; e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rsv_valid_i = 1'b0; rsv_vd_i = '0;
    chk_vs1_i = '0; chk_vs2_i = '0;
    wb_valid_i = '0; wb_vd_i = '0; wb_data_i = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    rsv_vd_i = 5'd5;
    @(negedge clk);
    check("reset_busy", 64'(busy_o), 64'h0);
    check("reset_en", 64'(vregw_en_o), 64'h0);
    check("reset_rsv_ready", 64'(rsv_ready_o), 64'h1);
    check("reset_err", 64'(err_o), 64'h0);
    check("reset_grant", 64'(wb_ready_o), 64'h0);
    step();

    // RAW on v5
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd5;
    @(negedge clk);
    check("raw_rsv_ready", 64'(rsv_ready_o), 64'h1);
    step();
    rsv_valid_i = 1'b0;
    chk_vs1_i = 5'd5; chk_vs2_i = 5'd0;
    @(negedge clk);
    check("raw_hazard_vs1", 64'(chk_hazard_o), 64'h1);
    check("raw_busy5", 64'(busy_o[5]), 64'h1);
    step();
    chk_vs1_i = 5'd0; chk_vs2_i = 5'd5;
    wb_issue(2'b01, 5'd5, 5'd0, {8{32'hA5A5A5A5}}, '0, 2'b01, "raw_grant");
    check("raw_hazard_vs2", 64'(chk_hazard_o), 64'h1);
    step();
    wb_valid_i = '0;
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd6;
    @(negedge clk);
    check("raw_en_n1", 64'(vregw_en_o), 64'h1);
    check("raw_hazard_n1", 64'(chk_hazard_o), 64'h1);
    step();
    rsv_valid_i = 1'b0;
    @(negedge clk);
    check("raw_hazard_n2", 64'(chk_hazard_o), 64'h0);
    check("raw_busy_n2", 64'(busy_o), 64'h40);
    check("raw_en_n2", 64'(vregw_en_o), 64'h0);
    step();

    // Round-robin from a reset pointer
    do_reset();
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd3;
    step();
    rsv_vd_i = 5'd4;
    step();
    rsv_valid_i = 1'b0;
    @(negedge clk);
    check("rr_busy", 64'(busy_o), 64'h18);
    step();
    for (int k = 0; k < 4; k++) begin
      w0 = 32'h3000_0000 + 32'(k);
      w1 = 32'h4000_0000 + 32'(k);
      wb_issue(2'b11, 5'd3, 5'd4, {8{w0}}, {8{w1}}, (k % 2 == 0) ? 2'b01 : 2'b10, "rr_both");
      step();
    end
    for (int k = 0; k < 3; k++) begin
      w1 = 32'h4100_0000 + 32'(k);
      wb_issue(2'b10, 5'd3, 5'd4, '0, {8{w1}}, 2'b10, "rr_req1_only");
      step();
    end
    wb_valid_i = '0;
    step();

    // WAW on v7 (pointer is 0 here)
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd7;
    @(negedge clk);
    check("waw_rsv_first", 64'(rsv_ready_o), 64'h1);
    step();
    @(negedge clk);
    check("waw_rsv_busy", 64'(rsv_ready_o), 64'h0);
    step();
    wb_issue(2'b01, 5'd7, 5'd0, {8{32'h7777_0000}}, '0, 2'b01, "waw_grant");
    check("waw_rsv_n", 64'(rsv_ready_o), 64'h0);
    step();
    wb_valid_i = '0;
    @(negedge clk);
    check("waw_rsv_n1", 64'(rsv_ready_o), 64'h0);
    step();
    @(negedge clk);
    check("waw_rsv_n2", 64'(rsv_ready_o), 64'h1);
    step();
    rsv_valid_i = 1'b0;
    @(negedge clk);
    check("waw_rebusy", 64'(busy_o[7]), 64'h1);
    step();

    // v0 handling and the unreserved-write error
    do_reset();
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd0;
    @(negedge clk);
    check("v0_rsv_ready", 64'(rsv_ready_o), 64'h1);
    step();
    rsv_valid_i = 1'b0;
    chk_vs1_i = 5'd0; chk_vs2_i = 5'd0;
    @(negedge clk);
    check("v0_busy", 64'(busy_o), 64'h0);
    check("v0_hazard", 64'(chk_hazard_o), 64'h0);
    step();
    wb_issue(2'b01, 5'd0, 5'd0, {8{32'hDEADBEEF}}, '0, 2'b01, "v0_grant");
    step();
    wb_valid_i = '0;
    @(negedge clk);
    check("v0_no_write", 64'(vregw_en_o), 64'h0);
    step();
    wb_issue(2'b10, 5'd0, 5'd9, '0, {8{32'h9999_9999}}, 2'b10, "err_grant");
    check("err_before", 64'(err_o), 64'h0);
    step();
    wb_valid_i = '0;
    @(negedge clk);
    check("err_set", 64'(err_o), 64'(EXP_ERR));
    step();
    @(negedge clk);
    check("err_sticky", 64'(err_o), 64'(EXP_ERR));
    step();

    // Asynchronous reset while a write is on the port (pointer is 0 here)
    rsv_valid_i = 1'b1; rsv_vd_i = 5'd12;
    step();
    rsv_valid_i = 1'b0;
    wb_issue(2'b01, 5'd12, 5'd0, {8{32'hC0C0C0C0}}, '0, 2'b01, "ar_grant");
    step();
    wb_valid_i = '0;
    @(negedge clk);
    check("ar_en_before", 64'(vregw_en_o), 64'h1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_en", 64'(vregw_en_o), 64'h0);
    check("ar_busy", 64'(busy_o), 64'h0);
    check("ar_err", 64'(err_o), 64'h0);
    check("ar_addr", 64'(vrd_addr_o), 64'h0);
    step();
    rst_n = 1'b1;
    step();
    step();
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
